// File: rtl/ci_pkg.sv
// Shared custom-instruction definitions.
// FSM encoding, CI field widths and well-known CI IDs.
package ci_pkg;

  localparam int CI_ID_W = 8;
  localparam int CI_OP_W = 32;

  localparam logic [CI_ID_W-1:0] CI_PROF_ID = 8'd8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } ci_state_t;

endpackage

// File: rtl/ci_timeout_counter.sv
// Latency counter for the CI initiator.
// Counts wait cycles and flags the timeout limit.
module ci_timeout_counter #(
  parameter int LAT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 enable,
  output logic [LAT_WIDTH-1:0] count,
  output logic                 terminal
);

  // Up-counter; clear has priority over enable.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + LAT_WIDTH'(1);
    end
  end

  assign terminal = (count == LAT_WIDTH'(TIMEOUT_CYCLES));

endmodule

// File: rtl/ci_initiator.sv
// CI master: issues one custom instruction per request
// and returns result, latency and timeout status.
module ci_initiator
  import ci_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int LAT_WIDTH      = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 reqValid,
  output logic                 reqReady,
  input  logic [7:0]           reqCiN,
  input  logic [31:0]          reqValueA,
  input  logic [31:0]          reqValueB,
  output logic                 ciStart,
  output logic [7:0]           ciN,
  output logic [31:0]          ciValueA,
  output logic [31:0]          ciValueB,
  input  logic                 ciDone,
  input  logic [31:0]          ciResult,
  output logic                 rspValid,
  input  logic                 rspReady,
  output logic [31:0]          rspResult,
  output logic [LAT_WIDTH-1:0] rspLatency,
  output logic                 rspTimeout
);

  ci_state_t state;
  ci_state_t state_nx;

  logic                 cnt_clr;
  logic                 cnt_en;
  logic [LAT_WIDTH-1:0] cnt;
  logic                 cnt_term;

  logic load_req;
  logic cap_done;
  logic cap_to;
  logic rsp_fire;

  ci_timeout_counter #(
    .LAT_WIDTH      (LAT_WIDTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_cnt (
    .clock    (clock),
    .reset    (reset),
    .clear    (cnt_clr),
    .enable   (cnt_en),
    .count    (cnt),
    .terminal (cnt_term)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and datapath strobes.
  always_comb begin
    state_nx = state;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    load_req = 1'b0;
    cap_done = 1'b0;
    cap_to   = 1'b0;
    rsp_fire = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (reqValid) begin
          load_req = 1'b1;
          cnt_clr  = 1'b1;
          state_nx = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (ciDone) begin
          cap_done = 1'b1;
          state_nx = ST_RESP;
        end else begin
          cnt_en   = 1'b1;
          state_nx = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (ciDone) begin
          cap_done = 1'b1;
          state_nx = ST_RESP;
        end else if (cnt_term) begin
          cap_to   = 1'b1;
          state_nx = ST_RESP;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_RESP: begin
        if (rspReady) begin
          rsp_fire = 1'b1;
          state_nx = ST_IDLE;
        end
      end
    endcase
  end

  // Operands: loaded on accept, zeroed on return to idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      ciN      <= '0;
      ciValueA <= '0;
      ciValueB <= '0;
    end else if (load_req) begin
      ciN      <= reqCiN;
      ciValueA <= reqValueA;
      ciValueB <= reqValueB;
    end else if (rsp_fire) begin
      ciN      <= '0;
      ciValueA <= '0;
      ciValueB <= '0;
    end
  end

  // Response capture on done or timeout.
  always_ff @(posedge clock) begin
    if (reset) begin
      rspResult  <= '0;
      rspLatency <= '0;
      rspTimeout <= 1'b0;
    end else if (cap_done) begin
      rspResult  <= ciResult;
      rspLatency <= cnt;
      rspTimeout <= 1'b0;
    end else if (cap_to) begin
      rspResult  <= '0;
      rspLatency <= cnt;
      rspTimeout <= 1'b1;
    end
  end

  assign reqReady = (state == ST_IDLE);
  assign ciStart  = (state == ST_ISSUE);
  assign rspValid = (state == ST_RESP);

endmodule

// File: tb/tb_ci_initiator.sv
// Self-checking bench for ci_initiator.
// Directed and random transactions against a reference model.
module tb_ci_initiator;
  import ci_pkg::*;

  localparam int TO = 10;
  localparam int LW = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          reqValid;
  logic          reqReady;
  logic [7:0]    reqCiN;
  logic [31:0]   reqValueA;
  logic [31:0]   reqValueB;
  logic          ciStart;
  logic [7:0]    ciN;
  logic [31:0]   ciValueA;
  logic [31:0]   ciValueB;
  logic          ciDone;
  logic [31:0]   ciResult;
  logic          rspValid;
  logic          rspReady;
  logic [31:0]   rspResult;
  logic [LW-1:0] rspLatency;
  logic          rspTimeout;

  int tests  = 0;
  int fails  = 0;
  int starts = 0;
  int cyc    = 0;

  ci_initiator #(
    .TIMEOUT_CYCLES (TO),
    .LAT_WIDTH      (LW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .reqValid   (reqValid),
    .reqReady   (reqReady),
    .reqCiN     (reqCiN),
    .reqValueA  (reqValueA),
    .reqValueB  (reqValueB),
    .ciStart    (ciStart),
    .ciN        (ciN),
    .ciValueA   (ciValueA),
    .ciValueB   (ciValueB),
    .ciDone     (ciDone),
    .ciResult   (ciResult),
    .rspValid   (rspValid),
    .rspReady   (rspReady),
    .rspResult  (rspResult),
    .rspLatency (rspLatency),
    .rspTimeout (rspTimeout)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) if (ciStart === 1'b1) starts <= starts + 1;

  function automatic logic [31:0] resp_fn(
    input logic [7:0] n, input logic [31:0] a, input logic [31:0] b);
    if (n == CI_PROF_ID) return 32'h1234ABCD;
    return (a ^ {b[15:0], b[31:16]}) + 32'(n);
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_reqReady", reqReady, 1);
    chk("rst_ciStart", ciStart, 0);
    chk("rst_ciN", ciN, 0);
    chk("rst_ciValueA", ciValueA, 0);
    chk("rst_ciValueB", ciValueB, 0);
    chk("rst_rspValid", rspValid, 0);
    chk("rst_rspResult", rspResult, 0);
    chk("rst_rspLatency", rspLatency, 0);
    chk("rst_rspTimeout", rspTimeout, 0);
  endtask

  task automatic idle_cycle(input logic late);
    @(posedge clock); #1;
    reqValid = 1'b0;
    ciDone   = late;
    @(negedge clock);
    chk("idle_rspValid", rspValid, 0);
    chk("idle_reqReady", reqReady, 1);
    chk("idle_ciStart", ciStart, 0);
    chk("idle_ciN", ciN, 0);
    chk("idle_ciValueA", ciValueA, 0);
    chk("idle_ciValueB", ciValueB, 0);
    ciDone = 1'b0;
  endtask

  // d: cycles from start to done (d > TO means no done in time)
  task automatic run_txn(input logic [7:0] n,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input int d,
                         input int stall);
    int k;
    int exp_k;
    int s0;
    logic [31:0]   er;
    logic [LW-1:0] el;
    logic          et;
    et    = (d > TO);
    exp_k = et ? TO + 1 : d + 1;
    er    = et ? 32'h0 : resp_fn(n, a, b);
    el    = et ? LW'(TO) : LW'(d);
    @(posedge clock); #1;
    reqValid  = 1'b1;
    reqCiN    = n;
    reqValueA = a;
    reqValueB = b;
    rspReady  = (stall == 0);
    ciDone    = 1'b0;
    @(negedge clock);
    chk("req_ready", reqReady, 1);
    chk("pre_start", ciStart, 0);
    s0 = starts;
    @(posedge clock); #1;
    reqValid  = 1'b0;
    reqCiN    = 8'($urandom);
    reqValueA = $urandom;
    reqValueB = $urandom;
    ciDone    = (d == 0);
    ciResult  = (d == 0) ? resp_fn(n, a, b) : $urandom;
    @(negedge clock);
    chk("issue_start", ciStart, 1);
    chk("issue_ciN", ciN, n);
    chk("issue_ciValueA", ciValueA, a);
    chk("issue_ciValueB", ciValueB, b);
    chk("issue_reqReady", reqReady, 0);
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock); #1;
      ciDone   = (i == d);
      ciResult = (i == d) ? resp_fn(n, a, b) : $urandom;
      @(negedge clock);
      if (rspValid === 1'b1) begin
        k = i;
        break;
      end
      chk("wait_start", ciStart, 0);
      chk("wait_ciN", ciN, n);
      chk("wait_ciValueA", ciValueA, a);
      chk("wait_ciValueB", ciValueB, b);
    end
    chk("rsp_cycle", k, exp_k);
    chk("rsp_result", rspResult, er);
    chk("rsp_latency", rspLatency, el);
    chk("rsp_timeout", rspTimeout, et);
    chk("one_start", starts - s0, 1);
    for (int s = 0; s < stall; s++) begin
      @(posedge clock); #1;
      reqValid = 1'b1;
      reqCiN   = 8'hFF;
      ciDone   = 1'b1;
      ciResult = $urandom;
      @(negedge clock);
      chk("bp_rspValid", rspValid, 1);
      chk("bp_result", rspResult, er);
      chk("bp_latency", rspLatency, el);
      chk("bp_timeout", rspTimeout, et);
      chk("bp_reqReady", reqReady, 0);
      chk("bp_ciStart", ciStart, 0);
    end
    if (stall > 0) begin
      @(posedge clock); #1;
      reqValid = 1'b0;
      rspReady = 1'b1;
      ciDone   = 1'b0;
    end
    idle_cycle(1'($urandom_range(0, 1)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  bn [3];
    logic [31:0] ba [3];
    logic [31:0] bb [3];
    int ic [3];
    int s0;
    int n;
    reset     = 1'b1;
    reqValid  = 1'b0;
    reqCiN    = '0;
    reqValueA = '0;
    reqValueB = '0;
    ciDone    = 1'b0;
    ciResult  = '0;
    rspReady  = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk_reset_vals();
    @(posedge clock); #1;
    reset = 1'b0;

    // same-cycle responder
    run_txn(CI_PROF_ID, 32'h0, 32'h0F, 0, 0);
    // delayed responder
    run_txn(CI_PROF_ID, 32'hDEAD_BEEF, 32'h5, 5, 0);
    run_txn(8'd3, 32'hA5A5_0001, 32'h1234_5678, 5, 0);
    // silent responder, late done lands in RESP
    run_txn(8'd9, 32'h1, 32'h2, 11, 2);
    run_txn(8'd10, 32'h3, 32'h4, 1000, 0);
    // done exactly at the timeout limit wins
    run_txn(8'd11, 32'h77, 32'h88, TO, 0);
    // backpressure then a normal request
    run_txn(8'd4, 32'hCAFE_F00D, 32'h0BAD_1DEA, 2, 4);
    run_txn(8'd5, 32'h1111_2222, 32'h3333_4444, 0, 0);

    // reset in WAIT
    @(posedge clock); #1;
    reqValid  = 1'b1;
    reqCiN    = 8'd6;
    reqValueA = 32'h600D;
    reqValueB = 32'hF00D;
    @(posedge clock); #1;
    reqValid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk_reset_vals();
    for (int i = 0; i < 12; i++) begin
      @(posedge clock); #1;
      ciDone = (i == 4);
      @(negedge clock);
      chk("post_rst_rspValid", rspValid, 0);
    end
    ciDone = 1'b0;
    run_txn(8'd6, 32'h600D, 32'hF00D, 3, 0);

    // back-to-back with reqValid held high
    for (int j = 0; j < 3; j++) begin
      bn[j] = (j == 0) ? CI_PROF_ID : 8'($urandom);
      ba[j] = $urandom;
      bb[j] = $urandom;
    end
    @(posedge clock); #1;
    reqValid  = 1'b1;
    reqCiN    = bn[0];
    reqValueA = ba[0];
    reqValueB = bb[0];
    rspReady  = 1'b1;
    s0 = starts;
    for (int j = 0; j < 3; j++) begin
      @(negedge clock);
      chk("b2b_reqReady", reqReady, 1);
      @(posedge clock); #1;
      if (j < 2) begin
        reqCiN    = bn[j+1];
        reqValueA = ba[j+1];
        reqValueB = bb[j+1];
      end else begin
        reqValid = 1'b0;
      end
      ciDone   = 1'b1;
      ciResult = resp_fn(bn[j], ba[j], bb[j]);
      @(negedge clock);
      chk("b2b_start", ciStart, 1);
      chk("b2b_ciN", ciN, bn[j]);
      chk("b2b_ciValueA", ciValueA, ba[j]);
      ic[j] = cyc;
      @(posedge clock); #1;
      ciDone   = 1'b0;
      ciResult = $urandom;
      @(negedge clock);
      chk("b2b_rspValid", rspValid, 1);
      chk("b2b_result", rspResult, resp_fn(bn[j], ba[j], bb[j]));
      chk("b2b_latency", rspLatency, 0);
      @(posedge clock); #1;
    end
    @(negedge clock);
    chk("b2b_starts", starts - s0, 3);
    chk("b2b_space01", ic[1] - ic[0], 3);
    chk("b2b_space12", ic[2] - ic[1], 3);

    // random transactions
    for (int t = 0; t < 16; t++) begin
      n = $urandom_range(0, 3);
      run_txn((n == 0) ? CI_PROF_ID : 8'($urandom),
              $urandom, $urandom,
              $urandom_range(0, TO + 3),
              $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
